// File: rtl/uart_pkg.sv
// Shared UART definitions: engine state encoding, parity mode codes, data width limits.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

    localparam int unsigned DATA_W_MIN = 5;
    localparam int unsigned DATA_W_MAX = 9;

    // Wide enough to index any legal data width.
    localparam int unsigned CNT_W = $clog2(DATA_W_MAX);

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] ST_BREAK  = 3'd5;
`endif

endpackage

// File: rtl/uart_tx_frame_if.sv
// Valid/ready word handshake between a producer and the UART transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_parity_gen.sv
// Combinational parity bit for a DATA_W-bit word; shared by the UART transmitter and receiver.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        par_mode,
    output logic              parity
);

    always_comb begin
        parity = 1'b0;
        case (par_mode)
            PAR_EVEN: parity = ^word;
            PAR_ODD:  parity = ~(^word);
            PAR_MARK: parity = 1'b1;
            default:  parity = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: DATA_W data bits, selectable parity, 1/2 stop bits,
// one-entry holding register. Define UART_TX_BREAK_EN to add the tx_break input and BREAK state.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             baud_tick,
    input  logic             tx_en,
    input  logic [1:0]       par_mode,
    input  logic             stop2,
`ifdef UART_TX_BREAK_EN
    input  logic             tx_break,
`endif
    uart_tx_frame_if.slave   tx,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             txd
);

    logic [2:0]        state;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] shift;
    logic              hold_full;
    logic [CNT_W-1:0]  bit_cnt;
    logic              stop_cnt;
    logic              par_en_l;
    logic              par_bit_l;
    logic              stop2_l;
    logic              par_bit;
    logic              accept;
    logic              stop_last;
    logic              frame_gate;
    logic              brk_req;
    logic              go_load;
`ifdef UART_TX_BREAK_EN
    logic              go_brk;
    logic              brk_stop;
`endif

    // Parity is taken from the held word with the live mode, then latched at load.
    uart_parity_gen #(.DATA_W(DATA_W)) u_parity (
        .word     (hold_data),
        .par_mode (par_mode),
        .parity   (par_bit)
    );

    assign tx.tx_ready = tx_en & ~hold_full & ~rst;
    assign accept      = tx.tx_valid & tx.tx_ready;
    assign tx_busy     = (state != ST_IDLE) | hold_full;

    always_comb begin
        stop_last  = (state == ST_STOP) && !(stop2_l && !stop_cnt);
        frame_gate = (state == ST_IDLE) || stop_last;
`ifdef UART_TX_BREAK_EN
        brk_req    = tx_break;
        go_brk     = frame_gate & brk_req;
`else
        brk_req    = 1'b0;
`endif
        go_load    = frame_gate & ~brk_req & hold_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            txd       <= 1'b1;
            hold_full <= 1'b0;
            hold_data <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_en_l  <= 1'b0;
            par_bit_l <= 1'b0;
            stop2_l   <= 1'b0;
            tx_done   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_stop  <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (!tx_en) begin
                state     <= ST_IDLE;
                txd       <= 1'b1;
                hold_full <= 1'b0;
`ifdef UART_TX_BREAK_EN
                brk_stop  <= 1'b0;
`endif
            end else begin
                if (accept) begin
                    hold_full <= 1'b1;
                    hold_data <= tx.tx_data;
                end
                if (baud_tick) begin
`ifdef UART_TX_BREAK_EN
                    if (stop_last && !brk_stop)
                        tx_done <= 1'b1;
`else
                    if (stop_last)
                        tx_done <= 1'b1;
`endif
                    // End of stop and idle share one launch path, so back-to-back frames have no gap.
`ifdef UART_TX_BREAK_EN
                    if (go_brk) begin
                        txd   <= 1'b0;
                        state <= ST_BREAK;
                    end else
`endif
                    if (go_load) begin
                        txd       <= 1'b0;
                        shift     <= hold_data;
                        par_en_l  <= (par_mode != PAR_NONE);
                        par_bit_l <= par_bit;
                        stop2_l   <= stop2;
                        hold_full <= 1'b0;
                        state     <= ST_START;
`ifdef UART_TX_BREAK_EN
                        brk_stop  <= 1'b0;
`endif
                    end else begin
                        case (state)
                            ST_IDLE: txd <= 1'b1;
                            ST_START: begin
                                txd     <= shift[0];
                                bit_cnt <= '0;
                                state   <= ST_DATA;
                            end
                            ST_DATA: begin
                                if (bit_cnt < CNT_W'(DATA_W - 1)) begin
                                    txd     <= shift[1];
                                    shift   <= shift >> 1;
                                    bit_cnt <= bit_cnt + CNT_W'(1);
                                end else if (par_en_l) begin
                                    txd   <= par_bit_l;
                                    state <= ST_PARITY;
                                end else begin
                                    txd      <= 1'b1;
                                    stop_cnt <= 1'b0;
                                    state    <= ST_STOP;
                                end
                            end
                            ST_PARITY: begin
                                txd      <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= ST_STOP;
                            end
                            ST_STOP: begin
                                if (!stop_last) begin
                                    stop_cnt <= 1'b1;
                                end else begin
                                    txd   <= 1'b1;
                                    state <= ST_IDLE;
`ifdef UART_TX_BREAK_EN
                                    brk_stop <= 1'b0;
`endif
                                end
                            end
`ifdef UART_TX_BREAK_EN
                            // Leaving break reuses STOP as a single, silent stop bit.
                            ST_BREAK: begin
                                if (!tx_break) begin
                                    txd      <= 1'b1;
                                    stop2_l  <= 1'b0;
                                    stop_cnt <= 1'b0;
                                    brk_stop <= 1'b1;
                                    state    <= ST_STOP;
                                end
                            end
`endif
                            default: begin
                                txd   <= 1'b1;
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame (DATA_W=8 and DATA_W=7 instances).
// Per-tick line/tx_done expectations come from a scoreboard queue filled as words are sent.
module tb_uart_tx_frame;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       tx_en = 1'b1;
    logic [1:0] par_mode = 2'b00;
    logic       stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic       tx_break = 1'b0;
`endif
    logic tx_busy, tx_done, txd;
    logic tx_busy7, tx_done7, txd7;

    uart_tx_frame_if #(.DATA_W(8)) tif ();
    uart_tx_frame_if #(.DATA_W(7)) tif7 ();

    uart_tx_frame #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_en(tx_en),
        .par_mode(par_mode), .stop2(stop2),
`ifdef UART_TX_BREAK_EN
        .tx_break(tx_break),
`endif
        .tx(tif), .tx_busy(tx_busy), .tx_done(tx_done), .txd(txd)
    );

    uart_tx_frame #(.DATA_W(7)) dut7 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_en(tx_en),
        .par_mode(par_mode), .stop2(stop2),
`ifdef UART_TX_BREAK_EN
        .tx_break(tx_break),
`endif
        .tx(tif7), .tx_busy(tx_busy7), .tx_done(tx_done7), .txd(txd7)
    );

    always #5 clk = ~clk;

    int unsigned tick_div = 0;
    always @(negedge clk) begin
        tick_div  = (tick_div + 1) % 4;
        baud_tick = (tick_div == 0);
    end

    typedef struct { logic b; logic last; } sb_t;
    typedef struct {
        logic [7:0]  data;
        logic [1:0]  mode;
        logic        stop2;
        logic        par;
        int unsigned len;
        logic        chain;
    } vec_t;

    sb_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic pending = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-tick line monitor for the 8-bit instance.
    always @(posedge clk) begin : monitor
        logic tk;
        logic exp_b;
        logic exp_d;
        sb_t  e;
        tk = baud_tick;
        #1;
        if (!rst) begin
            if (tk) begin
                exp_d   = pending;
                pending = 1'b0;
                exp_b   = 1'b1;
                if (sb.size() != 0) begin
                    e       = sb.pop_front();
                    exp_b   = e.b;
                    pending = e.last;
                end
                check("txd", 16'(txd), 16'(exp_b));
                check("tx_done", 16'(tx_done), 16'(exp_d));
            end else begin
                check("tx_done_between_ticks", 16'(tx_done), 16'h0);
            end
        end
    end

    task automatic push_frame(input vec_t v);
        logic        pe;
        int unsigned nstop;
        pe = (v.mode != 2'b00);
        sb.push_back('{1'b0, 1'b0});
        for (int i = 0; i < 8; i++) sb.push_back('{v.data[i], 1'b0});
        if (pe) sb.push_back('{v.par, 1'b0});
        nstop = v.len - 9 - (pe ? 1 : 0);
        for (int unsigned k = 0; k < nstop; k++) sb.push_back('{1'b1, k == nstop - 1});
    endtask

    task automatic wait_slot();
        int unsigned budget = 0;
        do begin
            @(negedge clk); #1; budget++;
        end while (!(tif.tx_ready && !baud_tick) && budget < 400);
        if (budget >= 400) check("ready_timeout", 16'(tif.tx_ready), 16'h1);
    endtask

    task automatic send(input vec_t v);
        int unsigned budget = 0;
        wait_slot();
        par_mode     = v.mode;
        stop2        = v.stop2;
        tif.tx_valid = 1'b1;
        tif.tx_data  = v.data;
        @(posedge clk); #1;
        push_frame(v);
        tif.tx_valid = 1'b0;
        tif.tx_data  = 8'($urandom);
        @(negedge clk); #1;
        check("ready_drop_held", 16'(tif.tx_ready), 16'h0);
        check("busy_held", 16'(tx_busy), 16'h1);
        do begin
            @(negedge clk); #1; budget++;
        end while (!tif.tx_ready && budget < 400);
        if (budget >= 400) check("load_timeout", 16'(tif.tx_ready), 16'h1);
        // Configuration changes after load must not affect the frame in flight.
        par_mode = ~v.mode;
        stop2    = ~v.stop2;
    endtask

    task automatic wait_idle();
        int unsigned budget = 0;
        do begin
            @(negedge clk); #1; budget++;
        end while (!(sb.size() == 0 && !pending && !tx_busy) && budget < 400);
        if (budget >= 400) check("idle_timeout", 16'(tx_busy), 16'h0);
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (!baud_tick);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t       vt[9];
        vec_t       v;
        logic [9:0] exp7;

        vt[0] = '{8'hA5, 2'b01, 1'b0, 1'b0, 11, 1'b0};
        vt[1] = '{8'h55, 2'b00, 1'b0, 1'b0, 10, 1'b1};
        vt[2] = '{8'h0F, 2'b00, 1'b0, 1'b0, 10, 1'b0};
        vt[3] = '{8'h00, 2'b10, 1'b0, 1'b1, 11, 1'b0};
        vt[4] = '{8'hFF, 2'b11, 1'b0, 1'b1, 11, 1'b0};
        vt[5] = '{8'h3C, 2'b01, 1'b1, 1'b0, 12, 1'b0};
        vt[6] = '{8'h81, 2'b10, 1'b0, 1'b1, 11, 1'b1};
        vt[7] = '{8'h96, 2'b01, 1'b1, 1'b0, 12, 1'b0};
        vt[8] = '{8'h07, 2'b01, 1'b0, 1'b1, 11, 1'b0};

        tif.tx_valid  = 1'b0;
        tif.tx_data   = '0;
        tif7.tx_valid = 1'b0;
        tif7.tx_data  = '0;

        // Reset state, with tx_en already high.
        repeat (3) @(negedge clk);
        #1;
        check("rst_txd", 16'(txd), 16'h1);
        check("rst_ready", 16'(tif.tx_ready), 16'h0);
        check("rst_busy", 16'(tx_busy), 16'h0);
        check("rst_done", 16'(tx_done), 16'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("ready_after_rst", 16'(tif.tx_ready), 16'h1);

        for (int i = 0; i < 9; i++) begin
            send(vt[i]);
            if (!vt[i].chain) wait_idle();
        end

        // Abort during data bit 3, with a word offered while disabled.
        v = '{8'hC3, 2'b01, 1'b0, 1'b0, 11, 1'b0};
        send(v);
        repeat (4) wait_tick();
        @(negedge clk); #1;
        while (baud_tick) begin @(negedge clk); #1; end
        tx_en        = 1'b0;
        sb.delete();
        pending      = 1'b0;
        tif.tx_valid = 1'b1;
        tif.tx_data  = 8'hEE;
        @(posedge clk); #1;
        check("abort_txd", 16'(txd), 16'h1);
        check("abort_busy", 16'(tx_busy), 16'h0);
        check("abort_ready", 16'(tif.tx_ready), 16'h0);
        repeat (12) @(negedge clk);
        tif.tx_valid = 1'b0;
        tx_en        = 1'b1;
        @(negedge clk); #1;
        check("abort_no_capture", 16'(tx_busy), 16'h0);
        v = '{8'h3C, 2'b01, 1'b0, 1'b0, 11, 1'b0};
        send(v);
        wait_idle();

        // DATA_W=7, two stop bits, 0x41: 10 line ticks then tx_done.
        exp7 = 10'b1110000010;
        do begin @(negedge clk); #1; end while (!(tif7.tx_ready && !baud_tick));
        par_mode      = 2'b00;
        stop2         = 1'b1;
        tif7.tx_valid = 1'b1;
        tif7.tx_data  = 7'h41;
        @(posedge clk); #1;
        tif7.tx_valid = 1'b0;
        check("w7_busy", 16'(tx_busy7), 16'h1);
        for (int k = 0; k < 11; k++) begin
            wait_tick();
            #1;
            if (k == 1) stop2 = 1'b0;
            if (k < 10) begin
                check("w7_txd", 16'(txd7), 16'(exp7[k]));
                check("w7_done_early", 16'(tx_done7), 16'h0);
            end else begin
                check("w7_txd_idle", 16'(txd7), 16'h1);
                check("w7_done", 16'(tx_done7), 16'h1);
            end
        end

        // Asynchronous reset while a zero data bit is on the line.
        v = '{8'h00, 2'b00, 1'b0, 1'b0, 10, 1'b0};
        send(v);
        repeat (2) wait_tick();
        @(negedge clk); #1;
        check("pre_rst_txd", 16'(txd), 16'h0);
        rst     = 1'b1;
        sb.delete();
        pending = 1'b0;
        #1;
        check("async_rst_txd", 16'(txd), 16'h1);
        check("async_rst_busy", 16'(tx_busy), 16'h0);
        check("async_rst_ready", 16'(tif.tx_ready), 16'h0);
        check("async_rst_done", 16'(tx_done), 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("no_resume_busy", 16'(tx_busy), 16'h0);
        check("no_resume_txd", 16'(txd), 16'h1);
        v = '{8'h96, 2'b01, 1'b1, 1'b0, 12, 1'b0};
        send(v);
        wait_idle();

`ifdef UART_TX_BREAK_EN
        // Break for 15 ticks, then one high tick and no tx_done.
        do begin @(negedge clk); #1; end while (!baud_tick);
        tx_break = 1'b1;
        for (int k = 0; k < 15; k++) sb.push_back('{1'b0, 1'b0});
        sb.push_back('{1'b1, 1'b0});
        repeat (15) wait_tick();
        #1;
        check("brk_busy", 16'(tx_busy), 16'h1);
        @(negedge clk);
        tx_break = 1'b0;
        wait_idle();
`endif

        repeat (8) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
